// File: rtl/cmul_pkg.sv
// cmul_pkg: shared constants and helpers for the complex multiplier.
// Rounding mode codes and full-precision width computation.
package cmul_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int ROUND_CONV    = 2;

  function automatic int full_w(input int in_w, input int coef_w);
    return in_w + coef_w + 1;
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// cmul_round_sat: shift by FRAC with selectable rounding, then
// clamp or wrap to OUT_W and flag out-of-range values.
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int IW         = 33,
  parameter int FRAC       = 15,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int SAT        = 1,
  parameter int OUT_W      = 16
) (
  input  logic signed [IW-1:0]    x,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  // Wide enough for the rounding carry and for any OUT_W.
  localparam int EW = IW + OUT_W + 2;
  localparam logic [EW-1:0] ONE  = EW'(1);
  localparam logic [EW-1:0] HALF = ONE << (FRAC - 1);

  logic        [EW-1:0]      xe;
  logic        [EW-1:0]      rnd;
  logic        [EW-1:0]      sum;
  logic signed [EW-1:0]      sh;
  logic        [EW-OUT_W:0]  hi;

  // Round, shift, then range-check the bits above the OUT_W sign bit.
  always_comb begin
    xe  = {{(EW-IW){x[IW-1]}}, x};
    rnd = '0;
    if (ROUND_MODE == ROUND_HALF_UP) begin
      rnd = HALF;
    end else if (ROUND_MODE == ROUND_CONV) begin
      rnd = HALF - ONE + {{(EW-1){1'b0}}, x[FRAC]};
    end
    sum = xe + rnd;
    sh  = $signed(sum) >>> FRAC;
    hi  = sh[EW-1:OUT_W-1];
    ovf = !((&hi) || !(|hi));
    y   = sh[OUT_W-1:0];
    if ((SAT != 0) && ovf) begin
      y = sh[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                   : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cmul_pipe.sv
// cmul_pipe: three-stage complex multiplier with conjugation,
// rounding, saturation and a single global pipeline enable.
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 16,
  parameter int FRAC       = 15,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int SAT        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   a_re,
  input  logic signed [IN_W-1:0]   a_im,
  input  logic signed [COEF_W-1:0] b_re,
  input  logic signed [COEF_W-1:0] b_im,
  input  logic                     in_conj,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic                     out_last,
  output logic                     out_ovf,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int PW = IN_W + COEF_W;
  localparam int FW = full_w(IN_W, COEF_W);

  logic en;

  logic s1_v_q, s1_v_d, s1_conj_q, s1_conj_d;
  logic s1_last_q, s1_last_d;
  logic signed [IN_W-1:0]   ar_q, ar_d, ai_q, ai_d;
  logic signed [COEF_W-1:0] br_q, br_d, bi_q, bi_d;

  logic s2_v_q, s2_v_d, s2_conj_q, s2_conj_d;
  logic s2_last_q, s2_last_d;
  logic signed [PW-1:0] rr_q, rr_d, ii_q, ii_d;
  logic signed [PW-1:0] ri_q, ri_d, ir_q, ir_d;

  logic s3_v_q, s3_v_d, last_q, last_d;
  logic ovf_q, ovf_d, sticky_q, sticky_d;
  logic signed [OUT_W-1:0] re_q, re_d, im_q, im_d;

  logic signed [FW-1:0]    re_full, im_full;
  logic signed [OUT_W-1:0] re_y, im_y;
  logic                    re_ovf, im_ovf;

  assign in_ready   = en;
  assign out_valid  = s3_v_q;
  assign out_re     = re_q;
  assign out_im     = im_q;
  assign out_last   = last_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

  // S1 operand capture and S2 partial products, both gated by en.
  always_comb begin
    en        = !s3_v_q || out_ready;
    s1_v_d    = s1_v_q;
    s1_conj_d = s1_conj_q;
    s1_last_d = s1_last_q;
    ar_d      = ar_q;
    ai_d      = ai_q;
    br_d      = br_q;
    bi_d      = bi_q;
    s2_v_d    = s2_v_q;
    s2_conj_d = s2_conj_q;
    s2_last_d = s2_last_q;
    rr_d      = rr_q;
    ii_d      = ii_q;
    ri_d      = ri_q;
    ir_d      = ir_q;
    if (en) begin
      s1_v_d    = in_valid;
      s1_conj_d = in_conj;
      s1_last_d = in_last;
      ar_d      = a_re;
      ai_d      = a_im;
      br_d      = b_re;
      bi_d      = b_im;
      s2_v_d    = s1_v_q;
      s2_conj_d = s1_conj_q;
      s2_last_d = s1_last_q;
      rr_d = $signed({{COEF_W{ar_q[IN_W-1]}}, ar_q})
           * $signed({{IN_W{br_q[COEF_W-1]}}, br_q});
      ii_d = $signed({{COEF_W{ai_q[IN_W-1]}}, ai_q})
           * $signed({{IN_W{bi_q[COEF_W-1]}}, bi_q});
      ri_d = $signed({{COEF_W{ar_q[IN_W-1]}}, ar_q})
           * $signed({{IN_W{bi_q[COEF_W-1]}}, bi_q});
      ir_d = $signed({{COEF_W{ai_q[IN_W-1]}}, ai_q})
           * $signed({{IN_W{br_q[COEF_W-1]}}, br_q});
    end
  end

  // Conjugation picks add vs subtract so b is never negated.
  always_comb begin
    if (s2_conj_q) begin
      re_full = {rr_q[PW-1], rr_q} + {ii_q[PW-1], ii_q};
      im_full = {ir_q[PW-1], ir_q} - {ri_q[PW-1], ri_q};
    end else begin
      re_full = {rr_q[PW-1], rr_q} - {ii_q[PW-1], ii_q};
      im_full = {ri_q[PW-1], ri_q} + {ir_q[PW-1], ir_q};
    end
  end

  cmul_round_sat #(
    .IW(FW), .FRAC(FRAC), .ROUND_MODE(ROUND_MODE),
    .SAT(SAT), .OUT_W(OUT_W)
  ) u_rs_re (
    .x(re_full), .y(re_y), .ovf(re_ovf)
  );

  cmul_round_sat #(
    .IW(FW), .FRAC(FRAC), .ROUND_MODE(ROUND_MODE),
    .SAT(SAT), .OUT_W(OUT_W)
  ) u_rs_im (
    .x(im_full), .y(im_y), .ovf(im_ovf)
  );

  // S3 output register and sticky overflow; a new overflow beats clear.
  always_comb begin
    s3_v_d   = s3_v_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    re_d     = re_q;
    im_d     = im_q;
    sticky_d = sticky_q;
    if (en) begin
      s3_v_d = s2_v_q;
      last_d = s2_last_q;
      ovf_d  = re_ovf || im_ovf;
      re_d   = re_y;
      im_d   = im_y;
    end
    if (ovf_clr) begin
      sticky_d = 1'b0;
    end
    if (s3_v_q && out_ready && ovf_q) begin
      sticky_d = 1'b1;
    end
  end

  // Pipeline state; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_conj_q <= 1'b0;
      s1_last_q <= 1'b0;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
      bi_q      <= '0;
      s2_v_q    <= 1'b0;
      s2_conj_q <= 1'b0;
      s2_last_q <= 1'b0;
      rr_q      <= '0;
      ii_q      <= '0;
      ri_q      <= '0;
      ir_q      <= '0;
      s3_v_q    <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      sticky_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_conj_q <= s1_conj_d;
      s1_last_q <= s1_last_d;
      ar_q      <= ar_d;
      ai_q      <= ai_d;
      br_q      <= br_d;
      bi_q      <= bi_d;
      s2_v_q    <= s2_v_d;
      s2_conj_q <= s2_conj_d;
      s2_last_q <= s2_last_d;
      rr_q      <= rr_d;
      ii_q      <= ii_d;
      ri_q      <= ri_d;
      ir_q      <= ir_d;
      s3_v_q    <= s3_v_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      re_q      <= re_d;
      im_q      <= im_d;
      sticky_q  <= sticky_d;
    end
  end

endmodule

// File: doc/cmul_pipe.md
# cmul_pipe

Pipelined, parametrised complex multiplier with valid/ready flow control, per-sample conjugation, selectable rounding and output saturation. It is the general twiddle/coefficient multiplier for the FFT datapath: data on port a, coefficient on port b. A frame marker travels through the pipeline alongside each sample. Input, coefficient and output widths are independent, and overflow is reported per sample and as a sticky flag.

## Interface
- IN_W, 16, width of a_re/a_im (signed)
- COEF_W, 16, width of b_re/b_im (signed)
- OUT_W, 16, width of out_re/out_im (signed)
- FRAC, 15, right shift applied to the full-precision result; legal range 1..IN_W+COEF_W-1
- ROUND_MODE, 1, 0 = truncate (floor), 1 = round half up, 2 = convergent (half to even)
- SAT, 1, 1 = saturate to OUT_W, 0 = wrap (keep low OUT_W bits)

Ports:
- clk  in  1  clock; one clock domain; reset is asynchronous and active-high
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts the sample this cycle
- a_re, a_im  in  IN_W  data operand
- b_re, b_im  in  COEF_W  coefficient operand
- in_conj  in  1  multiply by conj(b) for this sample
- in_last  in  1  frame marker, passed through unchanged
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output
- out_re, out_im  out  OUT_W  result
- out_last  out  1  delayed in_last
- out_ovf  out  1  this output saturated or wrapped (either part)
- ovf_sticky  out  1  OR of all out_ovf since reset or clear
- ovf_clr  in  1  synchronous clear of ovf_sticky

## Operation
- Transfer occurs when valid && ready, on both sides.
- Result, full precision, width IN_W+COEF_W+1:
  - conj = 0: re = aR·bR − aI·bI, im = aR·bI + aI·bR.
  - conj = 1: re = aR·bR + aI·bI, im = aI·bR − aR·bI.
  - Conjugation is done by the add/subtract selection, never by negating b, so b = −2^(COEF_W−1) is exact.
- Scaling is an arithmetic right shift by FRAC:
  - Truncate: plain shift.
  - Half up: add 2^(FRAC−1), then shift.
  - Convergent: add 2^(FRAC−1) − 1 + (bit FRAC of the unrounded value), then shift.
- Range reduction to OUT_W:
  - SAT = 1: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - SAT = 0: keep the low OUT_W bits.
  - out_ovf = 1 if either part was out of range, regardless of SAT.
- ovf_sticky:
  - Sets on any transferred output with out_ovf.
  - ovf_clr clears it.
  - ovf_clr in the same cycle as a new overflow: the set wins.
- in_conj and in_last are pipelined with their sample.

## Timing
- Three register stages:
  - S1: registered operands.
  - S2: four products.
  - S3: add/sub, round, saturate.
- Latency: 3 cycles from input transfer to out_valid when not stalled.
- Global enable: en = !out_valid || out_ready; in_ready = en, a combinational function of out_ready and the S3 valid.
- With en = 0, all stages hold, and out_re/out_im/out_last/out_ovf stay stable while out_valid = 1.
- Bubbles do not collapse inside the pipeline. Throughput is 1 sample/cycle with out_ready held high.
- Per-stage valid bits advance on en; data registers may load unconditionally on en.
- Reset values:
  - All valid bits, out_valid, out_last, out_ovf and ovf_sticky are 0.
  - out_re and out_im are 0.
- Reset mid-operation discards all in-flight samples. The first output after reset release needs a fresh input.
- in_valid asserted during a stall is not accepted (in_ready = 0), and the source must hold its data.

## Structure
- Package cmul_pkg:
  - Round-mode constants ROUND_TRUNC = 0, ROUND_HALF_UP = 1, ROUND_CONV = 2.
  - A function computing the full-precision width.
- Sub-module cmul_round_sat:
  - Parameters: in width, FRAC, ROUND_MODE, SAT, OUT_W.
  - Combinational shift/round/clamp plus the ovf bit.
  - Instantiated twice in S3, once for re and once for im.

## Test plan
All scenarios use IN_W = COEF_W = OUT_W = 16, FRAC = 15.
- Basic: a = (16384, 0), b = (16384, 0) → out = (8192, 0) exactly 3 cycles after transfer, out_ovf = 0.
- Conj: a = (100, 200), b = (16384, 16384).
  - conj = 0 → (−50, 150).
  - conj = 1 → (150, 50).
- Rounding: a = (1, 0) and a = (−1, 0), each with b = (16384, 0).
  - Truncate → 0 / −1.
  - Half up → 1 / 0.
  - Convergent → 0 / 0.
  - Also a = (3, 0): half up → 2, convergent → 2.
- Saturation: a = (−32768, −32768), b = (−32768, 32767).
  - SAT = 1 → (32767, 1).
  - SAT = 0 → re = −1 (wrapped), im = 1.
  - Both cases: out_ovf = 1, ovf_sticky = 1 until ovf_clr; a simultaneous clear and overflow keeps it at 1.
- Backpressure: stream 20 samples with in_last on the 20th while out_ready toggles randomly.
  - Output order and values match the model, with no loss or duplication.
  - out_last appears only on the 20th output.
  - Outputs are stable while stalled.
- Reset mid-stream: assert rst with 3 samples in flight.
  - out_valid drops immediately (asynchronous).
  - None of those samples ever appear.
  - ovf_sticky = 0.
